// File: rtl/key_event_encoder.sv
// key_event_encoder: turns debounced key levels into PRESS / SHORT_REL / LONG_REL (/ REPEAT) events.
// Latency: an isolated edge at cycle N gives ev_valid at N+3 (pressed N+1, slot N+2, FIFO N+3).
// Backpressure: valid/ready on the event port; with the FIFO full, events wait in per-channel slots,
//   and an event that finds its slot still occupied is dropped and sets the sticky overflow flag.
// Ports: clk, rst_n (async, active low); in[WIDTH] debounced levels; ev_valid/ev_ready/ev_code/ev_type
//   event stream; pressed[WIDTH] registered copy of in; overflow sticky lost-event flag, ovf_clr clears it.
// Option: define KEY_EVENT_REPEAT_EN to emit REPEAT events every REPEAT_TICKS ticks while in LONG.

// key_event_fifo: generic show-ahead FIFO with wrap-bit pointers.
// Latency: written entry visible on rd_dat the cycle after the write.
// Backpressure: wr_rdy low only when full and not popping; simultaneous push+pop allowed when full.
module key_event_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    // Same index with differing wrap bits means the write pointer lapped the read pointer.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_vld = ~empty;
    assign pop    = rd_vld & rd_rdy;
    assign wr_rdy = ~full | pop;
    assign push   = wr_vld & wr_rdy;
    // Gated so the head reads as zero while empty, including straight out of reset.
    assign rd_dat = rd_vld ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

// key_event_encoder: per-channel press/hold FSMs feeding one-entry slots, an arbiter and an event FIFO.
// Latency: edge at cycle N -> ev_valid at N+3.
// Backpressure: FIFO full stalls the arbiter; slots hold one event each; extra events set overflow.
module key_event_encoder #(
    parameter int WIDTH        = 4,
    parameter int RATE         = 125000,
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int DEPTH        = 8,
    localparam int CW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [CW-1:0]    ev_code,
    output logic [1:0]       ev_type,
    output logic [WIDTH-1:0] pressed,
    output logic             overflow,
    input  logic             ovf_clr
);
    localparam int TW   = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW   = $clog2(HMAX + 1);

    typedef enum logic [1:0] {
        EV_PRESS     = 2'b00,
        EV_SHORT_REL = 2'b01,
        EV_LONG_REL  = 2'b10,
        EV_REPEAT    = 2'b11
    } ev_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HELD = 2'b01,
        ST_LONG = 2'b10
    } state_t;

    typedef struct packed {
        logic [CW-1:0] code;
        ev_type_t      typ;
    } ev_t;

    // Hold-timer tick
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(RATE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Edge detection against the registered copy
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    assign rise = in & ~pressed;
    assign fall = ~in & pressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pressed <= '0;
        else        pressed <= in;
    end

    // Per-channel FSMs; emits are registered and land in the slot one cycle later
    state_t           state_q  [WIDTH];
    state_t           state_d  [WIDTH];
    logic [HW-1:0]    hold_q   [WIDTH];
    logic [HW-1:0]    hold_d   [WIDTH];
    logic [WIDTH-1:0] emit_d;
    ev_type_t         emit_typ_d [WIDTH];
    logic [WIDTH-1:0] emit_q;
    ev_type_t         emit_typ_q [WIDTH];

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            state_d[k]    = state_q[k];
            hold_d[k]     = hold_q[k];
            emit_d[k]     = 1'b0;
            emit_typ_d[k] = EV_PRESS;
            case (state_q[k])
                ST_IDLE: begin
                    if (rise[k]) begin
                        emit_d[k]     = 1'b1;
                        emit_typ_d[k] = EV_PRESS;
                        hold_d[k]     = '0;
                        state_d[k]    = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (fall[k]) begin
                        emit_d[k]     = 1'b1;
                        emit_typ_d[k] = EV_SHORT_REL;
                        state_d[k]    = ST_IDLE;
                    end else if (tick) begin
                        if (hold_q[k] == HW'(LONG_TICKS - 1)) begin
                            hold_d[k]  = '0;
                            state_d[k] = ST_LONG;
                        end else if (hold_q[k] != HW'(HMAX)) begin
                            hold_d[k] = hold_q[k] + 1'b1;
                        end
                    end
                end
                ST_LONG: begin
                    if (fall[k]) begin
                        emit_d[k]     = 1'b1;
                        emit_typ_d[k] = EV_LONG_REL;
                        state_d[k]    = ST_IDLE;
`ifdef KEY_EVENT_REPEAT_EN
                    end else if (tick) begin
                        if (hold_q[k] == HW'(REPEAT_TICKS - 1)) begin
                            emit_d[k]     = 1'b1;
                            emit_typ_d[k] = EV_REPEAT;
                            hold_d[k]     = '0;
                        end else if (hold_q[k] != HW'(HMAX)) begin
                            hold_d[k] = hold_q[k] + 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                    hold_d[k]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_q <= '0;
            for (int k = 0; k < WIDTH; k++) begin
                state_q[k]    <= ST_IDLE;
                hold_q[k]     <= '0;
                emit_typ_q[k] <= EV_PRESS;
            end
        end else begin
            emit_q <= emit_d;
            for (int k = 0; k < WIDTH; k++) begin
                state_q[k]    <= state_d[k];
                hold_q[k]     <= hold_d[k];
                emit_typ_q[k] <= emit_typ_d[k];
            end
        end
    end

    // Slots and lowest-index-first arbiter
    logic [WIDTH-1:0] slot_vld;
    ev_type_t         slot_typ [WIDTH];
    logic [WIDTH-1:0] grant;
    logic             fifo_wr_vld;
    logic             fifo_wr_rdy;
    ev_t              fifo_wr_dat;
    ev_t              fifo_rd_dat;
    logic             ovf_set;

    always_comb begin
        grant       = '0;
        fifo_wr_vld = 1'b0;
        fifo_wr_dat = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (slot_vld[k] && !fifo_wr_vld) begin
                fifo_wr_vld     = 1'b1;
                fifo_wr_dat.code = CW'(k);
                fifo_wr_dat.typ  = slot_typ[k];
                grant[k]        = fifo_wr_rdy;
            end
        end
    end

    // A slot being drained this cycle can take the new event; otherwise the new one is lost.
    assign ovf_set = |(emit_q & slot_vld & ~grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
            for (int k = 0; k < WIDTH; k++) slot_typ[k] <= EV_PRESS;
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                if (emit_q[k] && (!slot_vld[k] || grant[k])) begin
                    slot_vld[k] <= 1'b1;
                    slot_typ[k] <= emit_typ_q[k];
                end else if (grant[k]) begin
                    slot_vld[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    key_event_fifo #(
        .W     ($bits(ev_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (fifo_wr_vld),
        .wr_dat (fifo_wr_dat),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (ev_valid),
        .rd_rdy (ev_ready),
        .rd_dat (fifo_rd_dat)
    );

    assign ev_code = fifo_rd_dat.code;
    assign ev_type = fifo_rd_dat.typ;
endmodule

// File: tb/tb_key_event_encoder.sv
module tb_key_event_encoder;
    localparam logic [1:0] T_PRESS = 2'b00;
    localparam logic [1:0] T_SREL  = 2'b01;
    localparam logic [1:0] T_LREL  = 2'b10;
    localparam logic [1:0] T_REP   = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_code;
    logic [1:0] ev_type;
    logic [3:0] pressed;
    logic       overflow;
    logic       ovf_clr;

    key_event_encoder #(
        .WIDTH        (4),
        .RATE         (4),
        .LONG_TICKS   (3),
        .REPEAT_TICKS (2),
        .DEPTH        (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (key_in),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_code  (ev_code),
        .ev_type  (ev_type),
        .pressed  (pressed),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] in_v;
        logic       rdy;
        logic       e_vld;
        logic [1:0] e_code;
        logic [1:0] e_typ;
        logic [3:0] e_pressed;
        logic       e_ovf;
    } vec_t;

    typedef struct {
        logic [1:0] code;
        logic [1:0] typ;
        int         at;
    } rec_t;

    vec_t tv [22];
    rec_t cap_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs, clock once, leave time 1 unit after the edge for sampling.
    task automatic step(input logic [3:0] i, input logic r, input logic c);
        key_in   = i;
        ev_ready = r;
        ovf_clr  = c;
        @(posedge clk);
        #1;
    endtask

    // Run n cycles with fixed inputs, recording every handshaken head event.
    task automatic run_cap(input int n, input logic [3:0] i, input logic r);
        key_in   = i;
        ev_ready = r;
        ovf_clr  = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (ev_valid && ev_ready) cap_q.push_back('{ev_code, ev_type, cyc});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_ev(input string name, input int idx, input logic [1:0] code, input logic [1:0] typ);
        if (idx < cap_q.size()) begin
            chk({name, ".code"}, 32'(cap_q[idx].code), 32'(code));
            chk({name, ".type"}, 32'(cap_q[idx].typ), 32'(typ));
        end else begin
            chk({name, ".count"}, 32'(cap_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        // Short press on ch2, then ch0+ch3 rising together; ev_ready held high.
        tv[0]  = '{4'b0100, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0100, 1'b0};
        tv[1]  = '{4'b0100, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0100, 1'b0};
        tv[2]  = '{4'b0100, 1'b1, 1'b1, 2'd2, T_PRESS, 4'b0100, 1'b0};
        tv[3]  = '{4'b0100, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0100, 1'b0};
        tv[4]  = '{4'b0100, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0100, 1'b0};
        tv[5]  = '{4'b0100, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0100, 1'b0};
        tv[6]  = '{4'b0100, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0100, 1'b0};
        tv[7]  = '{4'b0100, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0100, 1'b0};
        tv[8]  = '{4'b0000, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0000, 1'b0};
        tv[9]  = '{4'b0000, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0000, 1'b0};
        tv[10] = '{4'b0000, 1'b1, 1'b1, 2'd2, T_SREL,  4'b0000, 1'b0};
        tv[11] = '{4'b0000, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0000, 1'b0};
        tv[12] = '{4'b1001, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b1001, 1'b0};
        tv[13] = '{4'b1001, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b1001, 1'b0};
        tv[14] = '{4'b1001, 1'b1, 1'b1, 2'd0, T_PRESS, 4'b1001, 1'b0};
        tv[15] = '{4'b1001, 1'b1, 1'b1, 2'd3, T_PRESS, 4'b1001, 1'b0};
        tv[16] = '{4'b1001, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b1001, 1'b0};
        tv[17] = '{4'b0000, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0000, 1'b0};
        tv[18] = '{4'b0000, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0000, 1'b0};
        tv[19] = '{4'b0000, 1'b1, 1'b1, 2'd0, T_SREL,  4'b0000, 1'b0};
        tv[20] = '{4'b0000, 1'b1, 1'b1, 2'd3, T_SREL,  4'b0000, 1'b0};
        tv[21] = '{4'b0000, 1'b1, 1'b0, 2'd0, T_PRESS, 4'b0000, 1'b0};

        rst_n    = 1'b0;
        key_in   = 4'b0000;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        #3;
        chk("rst.ev_valid", 32'(ev_valid), 32'd0);
        chk("rst.ev_code",  32'(ev_code),  32'd0);
        chk("rst.ev_type",  32'(ev_type),  32'd0);
        chk("rst.pressed",  32'(pressed),  32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 1'b0);

        // Cycle-accurate vector table
        for (int i = 0; i < 22; i++) begin
            step(tv[i].in_v, tv[i].rdy, 1'b0);
            chk($sformatf("vec%0d.ev_valid", i), 32'(ev_valid), 32'(tv[i].e_vld));
            if (tv[i].e_vld) begin
                chk($sformatf("vec%0d.ev_code", i), 32'(ev_code), 32'(tv[i].e_code));
                chk($sformatf("vec%0d.ev_type", i), 32'(ev_type), 32'(tv[i].e_typ));
            end
            chk($sformatf("vec%0d.pressed", i),  32'(pressed),  32'(tv[i].e_pressed));
            chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(tv[i].e_ovf));
        end

        // Long press on ch1
        cap_q.delete();
`ifdef KEY_EVENT_REPEAT_EN
        run_cap(40, 4'b0010, 1'b1);
`else
        run_cap(20, 4'b0010, 1'b1);
`endif
        run_cap(8, 4'b0000, 1'b1);
        chk_ev("long.ev0", 0, 2'd1, T_PRESS);
`ifdef KEY_EVENT_REPEAT_EN
        chk("long.enough_events", 32'(cap_q.size() >= 4), 32'd1);
        for (int i = 1; i + 1 < cap_q.size(); i++) begin
            chk($sformatf("long.rep%0d.type", i), 32'(cap_q[i].typ), 32'(T_REP));
            if (i > 1)
                chk($sformatf("long.rep%0d.spacing", i), 32'(cap_q[i].at - cap_q[i-1].at), 32'd8);
        end
        if (cap_q.size() > 0)
            chk("long.last.type", 32'(cap_q[cap_q.size()-1].typ), 32'(T_LREL));
`else
        chk_ev("long.ev1", 1, 2'd1, T_LREL);
        chk("long.count", 32'(cap_q.size()), 32'd2);
`endif
        chk("long.overflow", 32'(overflow), 32'd0);

        // Backpressure: 6 events on ch0 with ev_ready low
        for (int e = 0; e < 6; e++) begin
            step((e % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
            step((e % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0);
        chk("bp.ev_valid", 32'(ev_valid), 32'd1);
        chk("bp.head_code", 32'(ev_code), 32'd0);
        chk("bp.head_type", 32'(ev_type), 32'(T_PRESS));
        chk("bp.overflow", 32'(overflow), 32'd1);
        step(4'b0000, 1'b0, 1'b0);
        chk("bp.stable_valid", 32'(ev_valid), 32'd1);
        chk("bp.stable_type", 32'(ev_type), 32'(T_PRESS));
        cap_q.delete();
        run_cap(10, 4'b0000, 1'b1);
        chk("bp.drain_count", 32'(cap_q.size()), 32'd5);
        chk_ev("bp.ev0", 0, 2'd0, T_PRESS);
        chk_ev("bp.ev1", 1, 2'd0, T_SREL);
        chk_ev("bp.ev2", 2, 2'd0, T_PRESS);
        chk_ev("bp.ev3", 3, 2'd0, T_SREL);
        chk_ev("bp.ev4", 4, 2'd0, T_PRESS);
        chk("bp.overflow_sticky", 32'(overflow), 32'd1);
        step(4'b0000, 1'b1, 1'b1);
        chk("bp.overflow_clr", 32'(overflow), 32'd0);

        // Full FIFO plus pending slot, then a single pop cycle
        for (int e = 0; e < 4; e++) begin
            step((e % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
            step((e % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
        end
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        chk("full.ev_valid", 32'(ev_valid), 32'd1);
        chk("full.head_type", 32'(ev_type), 32'(T_PRESS));
        step(4'b0000, 1'b1, 1'b0);
        chk("full.pop_valid", 32'(ev_valid), 32'd1);
        chk("full.pop_head", 32'(ev_type), 32'(T_SREL));
        cap_q.delete();
        run_cap(10, 4'b0000, 1'b1);
        chk("full.drain_count", 32'(cap_q.size()), 32'd5);
        chk_ev("full.ev0", 0, 2'd0, T_SREL);
        chk_ev("full.ev1", 1, 2'd0, T_PRESS);
        chk_ev("full.ev2", 2, 2'd0, T_SREL);
        chk_ev("full.ev3", 3, 2'd1, T_PRESS);
        chk_ev("full.ev4", 4, 2'd1, T_SREL);
        chk("full.overflow", 32'(overflow), 32'd0);

        // Reset in the middle of a long press with queued events
        for (int i = 0; i < 16; i++) step(4'b0110, 1'b0, 1'b0);
        chk("mid.ev_valid", 32'(ev_valid), 32'd1);
        chk("mid.pressed", 32'(pressed), 32'h6);
        rst_n = 1'b0;
        #2;
        chk("arst.ev_valid", 32'(ev_valid), 32'd0);
        chk("arst.overflow", 32'(overflow), 32'd0);
        chk("arst.pressed",  32'(pressed),  32'd0);
        @(posedge clk);
        #1;
        chk("arst.next_valid", 32'(ev_valid), 32'd0);
        rst_n = 1'b1;
        cap_q.delete();
        run_cap(8, 4'b0110, 1'b1);
        run_cap(8, 4'b0000, 1'b1);
        chk("post.count", 32'(cap_q.size()), 32'd4);
        chk_ev("post.ev0", 0, 2'd1, T_PRESS);
        chk_ev("post.ev1", 1, 2'd2, T_PRESS);
        chk_ev("post.ev2", 2, 2'd1, T_SREL);
        chk_ev("post.ev3", 3, 2'd2, T_SREL);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
